clk_en_gen: RTL and testbench
=============================

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of divided clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8: divisor and phase field width.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: settle cycles before locked asserts (>=2).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic in this domain.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1: reconfiguration request.
REQ-007 SHALL have port cfg_ready, output, 1: reconfiguration accepted when high with cfg_valid.
REQ-008 SHALL have port cfg_ch, input, 3: target channel index.
REQ-009 SHALL have port cfg_div, input, DIV_W: divisor N; values 0 and 1 both mean divide-by-1.
REQ-010 SHALL have port cfg_phase, input, DIV_W: enable-pulse offset within the period.
REQ-011 SHALL have port clk_en, output, NUM_CH: one-cycle enable pulse per channel period.
REQ-012 SHALL have port div_clk, output, NUM_CH: divided level output per channel.
REQ-013 SHALL have port locked, output, 1: all channels running and phase-aligned.

Function
REQ-014 SHALL implement FSM WAIT -> LOCKED -> RELOCK -> LOCKED; WAIT and RELOCK count LOCK_CYCLES cycles, then enter LOCKED.
REQ-015 SHALL drive locked=1 only in LOCKED, first on the LOCK_CYCLES-th rising edge after rst_n deasserts.
REQ-016 SHALL drive cfg_ready=1 only in LOCKED; cfg_valid outside LOCKED is ignored.
REQ-017 SHALL, on handshake with cfg_ch<NUM_CH, store div/phase for that channel and enter RELOCK on the next edge.
REQ-018 SHALL accept and discard handshakes with cfg_ch>=NUM_CH; FSM stays LOCKED.
REQ-019 SHALL clamp stored phase to N-1 when cfg_phase>=N (phase 0 when N<=1).
REQ-020 SHALL hold every channel counter at 0 while not LOCKED, so all channels restart aligned.
REQ-021 SHALL count each channel 0..N-1 with wrap to 0 while LOCKED.
REQ-022 SHALL register clk_en[i]: high in cycles T+1+p+k*N, with T the first locked cycle and p the stored phase.
REQ-023 SHALL hold clk_en[i]=1 every cycle from T+1 for N<=1.
REQ-024 SHALL register div_clk[i]=1 when counter < ceil(N/2), else 0: 50 % duty for even N, high-biased for odd N, constant 1 for N<=1.
REQ-025 SHALL force clk_en and div_clk to 0 while not LOCKED.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear FSM to WAIT and clear the settle counter, channel counters, clk_en, div_clk, locked and cfg_ready.
REQ-027 SHALL reset channel i divisor to i+1 and phase to 0 (ch0 /1, ch1 /2).
REQ-028 SHALL, on reset mid-RELOCK or mid-period, discard pending config and restart from WAIT.

Configuration
REQ-029 SHALL compile div_clk generation only when CLK_EN_GEN_DIVCLK_EN is defined.
REQ-030 SHALL, without CLK_EN_GEN_DIVCLK_EN, tie div_clk to 0 and instantiate no div_clk registers; clk_en is unchanged.

Structure
REQ-031 SHALL place the FSM state enum and default DIV_W/LOCK_CYCLES constants in shared package clk_en_gen_pkg.
REQ-032 SHALL implement the per-channel counter, phase compare and div_clk logic in sub-module clk_en_chan, instantiated NUM_CH times.

Verification
REQ-033 SHALL cover: release rst_n, LOCK_CYCLES=16 -> locked rises on edge 16; clk_en[0] high every cycle from the next cycle; clk_en[1] high on alternate cycles.
REQ-034 SHALL cover: cfg ch1, div=4, phase=2 -> locked low for 16 cycles, then clk_en[1] at T+3, T+7, ...; div_clk[1] pattern 1,1,0,0.
REQ-035 SHALL cover: cfg ch0, div=5, phase=9 -> phase clamped to 4; clk_en[0] at T+5, T+10; div_clk[0] 1,1,1,0,0.
REQ-036 SHALL cover: cfg_valid held during RELOCK -> cfg_ready=0, no second update; request accepted once LOCKED.
REQ-037 SHALL cover: cfg_ch=7 with NUM_CH=2 -> handshake completes, locked stays 1, outputs unchanged.
REQ-038 SHALL cover: rst_n pulsed low mid-RELOCK -> all outputs 0 immediately; divisors restored to 1 and 2; relock after 16 cycles.

Source files
------------

// File: rtl/clk_en_gen_pkg.sv
// rtl/clk_en_gen_pkg.sv - shared FSM state type and default sizing constants for clk_en_gen
package clk_en_gen_pkg;

    localparam int DEF_DIV_W       = 8;
    localparam int DEF_LOCK_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_RELOCK = 2'd2
    } state_t;

endpackage

// File: rtl/clk_en_chan.sv
// rtl/clk_en_chan.sv - one clock-enable channel: config store, period counter, phase compare, div_clk
// Optional div_clk generation under CLK_EN_GEN_DIVCLK_EN.
module clk_en_chan
    import clk_en_gen_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_phase,
    output logic             clk_en,
    output logic             div_clk
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] phase_eff;
    logic             div_le1;

    // Divisors 0 and 1 collapse to 1; phase is clamped into the period.
    assign div_le1   = (wr_div <= DIV_W'(1));
    assign div_eff   = div_le1 ? DIV_W'(1) : wr_div;
    assign phase_eff = div_le1 ? '0 :
                       (wr_phase >= wr_div) ? (wr_div - DIV_W'(1)) : wr_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DIV_W'(RST_DIV);
            phase_q <= '0;
        end else if (wr) begin
            div_q   <= div_eff;
            phase_q <= phase_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else begin
            if (!run || cnt == div_q - DIV_W'(1))
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
            clk_en <= run && (cnt == phase_q);
        end
    end

`ifdef CLK_EN_GEN_DIVCLK_EN
    logic [DIV_W:0] half;

    // High for the first ceil(N/2) counts of the period.
    assign half = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_clk <= 1'b0;
        else
            div_clk <= run && ({1'b0, cnt} < half);
    end
`else
    assign div_clk = 1'b0;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel clock-enable generator with lock FSM and runtime reconfiguration
// Optional div_clk outputs compiled only when CLK_EN_GEN_DIVCLK_EN is defined.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] div_clk,
    output logic              locked
);

    localparam int SET_W = $clog2(LOCK_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [SET_W-1:0] settle;
    logic [SET_W-1:0] settle_next;
    logic             ch_ok;
    logic             hs;
    logic             run;

    assign locked    = (state == ST_LOCKED);
    assign cfg_ready = locked;
    assign hs        = cfg_valid && cfg_ready;
    assign ch_ok     = ({1'b0, cfg_ch} < 4'(NUM_CH));

    always_comb begin
        state_next  = state;
        settle_next = '0;
        case (state)
            ST_LOCKED: begin
                if (hs && ch_ok)
                    state_next = ST_RELOCK;
            end
            default: begin
                if (settle == SET_W'(LOCK_CYCLES - 1))
                    state_next = ST_LOCKED;
                else
                    settle_next = settle + SET_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_WAIT;
            settle <= '0;
        end else begin
            state  <= state_next;
            settle <= settle_next;
        end
    end

    // Channels only run while locked now and next cycle, so every relock restarts them aligned.
    assign run = locked && (state_next == ST_LOCKED);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (i + 1)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .wr       (hs && ch_ok && (cfg_ch == 3'(i))),
            .wr_div   (cfg_div),
            .wr_phase (cfg_phase),
            .clk_en   (clk_en[i]),
            .div_clk  (div_clk[i])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - directed self-checking bench for clk_en_gen
module tb_clk_en_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic [1:0] clk_en;
    logic [1:0] div_clk;
    logic       locked;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_en_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .clk_en    (clk_en),
        .div_clk   (div_clk),
        .locked    (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle j counts from T (first locked cycle, j=0).
    function automatic logic en_exp(int j, int n, int p);
        if (j < 1) return 1'b0;
        if (n <= 1) return 1'b1;
        return (j - 1 >= p) && (((j - 1 - p) % n) == 0);
    endfunction

    function automatic logic dc_exp(int j, int n);
`ifdef CLK_EN_GEN_DIVCLK_EN
        if (j < 1) return 1'b0;
        return (((j - 1) % n) < ((n + 1) / 2));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_cycle(input int j, input int n0, input int p0, input int n1, input int p1);
        chk($sformatf("locked j=%0d", j), {31'd0, locked}, 32'd1);
        chk($sformatf("clk_en j=%0d", j), {30'd0, clk_en},
            {30'd0, en_exp(j, n1, p1), en_exp(j, n0, p0)});
        chk($sformatf("div_clk j=%0d", j), {30'd0, div_clk},
            {30'd0, dc_exp(j, n1), dc_exp(j, n0)});
    endtask

    task automatic run(input int j0, input int cnt, input int n0, input int p0, input int n1, input int p1);
        for (int k = 0; k < cnt; k++) begin
            chk_cycle(j0 + k, n0, p0, n1, p1);
            step();
        end
    endtask

    // Call in the first settle cycle; returns in cycle T.
    task automatic wait_lock(input int settle_cycles, input logic held_req);
        for (int k = 0; k < settle_cycles; k++) begin
            chk($sformatf("settle locked k=%0d", k), {31'd0, locked}, 32'd0);
            chk($sformatf("settle clk_en k=%0d", k), {30'd0, clk_en}, 32'd0);
            if (held_req)
                chk($sformatf("settle cfg_ready k=%0d", k), {31'd0, cfg_ready}, 32'd0);
            step();
        end
    endtask

    task automatic cfg(input int ch, input int dv, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = 8'(dv);
        cfg_phase = 8'(ph);
        chk($sformatf("cfg_ready ch=%0d", ch), {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd0;
        cfg_phase = 8'd0;
        #12;
        chk("rst locked", {31'd0, locked}, 32'd0);
        chk("rst cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst clk_en", {30'd0, clk_en}, 32'd0);
        chk("rst div_clk", {30'd0, div_clk}, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_lock(15, 1'b0);
        step();
        chk("cfg_ready at T", {31'd0, cfg_ready}, 32'd1);
        run(0, 8, 1, 0, 2, 0);

        // ch1 /4 phase 2
        cfg(1, 4, 2);
        wait_lock(16, 1'b0);
        run(0, 12, 1, 0, 4, 2);

        // ch0 /5 phase 9 -> clamped to 4
        cfg(0, 5, 9);
        wait_lock(16, 1'b0);
        run(0, 12, 5, 4, 4, 2);

        // Request held through RELOCK is only taken once locked again.
        cfg(1, 3, 0);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 8'd6;
        cfg_phase = 8'd1;
        wait_lock(16, 1'b1);
        chk("held locked", {31'd0, locked}, 32'd1);
        chk("held cfg_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
        wait_lock(15, 1'b0);
        step();
        run(0, 14, 5, 4, 6, 1);

        // Out-of-range channel is handshaken and dropped.
        cfg_valid = 1'b1;
        cfg_ch    = 3'd7;
        cfg_div   = 8'd3;
        cfg_phase = 8'd0;
        chk("ch7 cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk_cycle(14, 5, 4, 6, 1);
        step();
        cfg_valid = 1'b0;
        run(15, 10, 5, 4, 6, 1);

        // Reset mid-RELOCK restores defaults.
        cfg(1, 4, 0);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #1;
        chk("midrelock rst locked", {31'd0, locked}, 32'd0);
        chk("midrelock rst cfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("midrelock rst clk_en", {30'd0, clk_en}, 32'd0);
        chk("midrelock rst div_clk", {30'd0, div_clk}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_lock(15, 1'b0);
        step();
        run(0, 8, 1, 0, 2, 0);

        // Asynchronous clear while clk_en[0] is high.
        chk("pre async clk_en0", {31'd0, clk_en[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst locked", {31'd0, locked}, 32'd0);
        chk("async rst clk_en", {30'd0, clk_en}, 32'd0);
        chk("async rst div_clk", {30'd0, div_clk}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
